// File: rtl/delayed_mem_responder.sv
// Memory-side responder for the val/rdy memory interface: word array, 2-entry in-order
// response FIFO, and programmable minimum intervals between request and response handshakes.
module delayed_mem_responder #(
    parameter int unsigned p_opaq_bits       = 8,
    parameter int unsigned p_addr_bits       = 32,
    parameter int unsigned p_data_bits       = 32,
    parameter int unsigned p_mem_words       = 256,
    parameter int unsigned p_recv_intv_delay = 1,
    parameter int unsigned p_send_intv_delay = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_val,
    output logic                   o_req_rdy,
    input  logic                   i_req_op,
    input  logic [p_opaq_bits-1:0] i_req_opaque,
    input  logic [p_addr_bits-1:0] i_req_addr,
    input  logic [p_data_bits-1:0] i_req_wdata,
    input  logic [3:0]             i_req_wstrb,
    output logic                   o_resp_val,
    input  logic                   i_resp_rdy,
    output logic                   o_resp_op,
    output logic [p_opaq_bits-1:0] o_resp_opaque,
    output logic [p_addr_bits-1:0] o_resp_addr,
    output logic [p_data_bits-1:0] o_resp_data
);

    localparam int unsigned c_idx_w  = $clog2(p_mem_words);
    localparam int unsigned c_rcnt_w = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay) : 1;
    localparam int unsigned c_scnt_w = (p_send_intv_delay > 1) ? $clog2(p_send_intv_delay) : 1;
    localparam logic [c_rcnt_w-1:0] c_rcnt_load = c_rcnt_w'(p_recv_intv_delay - 1);
    localparam logic [c_scnt_w-1:0] c_scnt_load = c_scnt_w'(p_send_intv_delay - 1);

    logic [p_data_bits-1:0] r_mem [p_mem_words];

    logic                   r_fifo_op     [2];
    logic [p_opaq_bits-1:0] r_fifo_opaque [2];
    logic [p_addr_bits-1:0] r_fifo_addr   [2];
    logic [p_data_bits-1:0] r_fifo_data   [2];
    logic                   r_head;
    logic [1:0]             r_count;
    logic [c_rcnt_w-1:0]    r_recv_cnt;
    logic [c_scnt_w-1:0]    r_send_cnt;

    logic               w_req_fire;
    logic               w_resp_fire;
    logic               w_tail;
    logic [c_idx_w-1:0] w_idx;

    // req_rdy is a function of state only (plus reset), never of resp_rdy or req_val
    assign o_req_rdy   = !i_rst && (r_recv_cnt == '0) && (r_count != 2'd2);
    assign o_resp_val  = (r_send_cnt == '0) && (r_count != 2'd0);
    assign w_req_fire  = i_req_val && o_req_rdy;
    assign w_resp_fire = o_resp_val && i_resp_rdy;
    assign w_tail      = r_head ^ r_count[0];
    assign w_idx       = i_req_addr[c_idx_w+1:2];

    // Array contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_req_fire && i_req_op) begin
            for (int b = 0; b < 4; b++) begin
                if (i_req_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_recv_cnt <= '0;
            r_send_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_op[i]     <= 1'b0;
                r_fifo_opaque[i] <= '0;
                r_fifo_addr[i]   <= '0;
                r_fifo_data[i]   <= '0;
            end
        end else begin
            if (w_req_fire) begin
                r_fifo_op[w_tail]     <= i_req_op;
                r_fifo_opaque[w_tail] <= i_req_opaque;
                r_fifo_addr[w_tail]   <= i_req_addr;
                r_fifo_data[w_tail]   <= i_req_op ? '0 : r_mem[w_idx];
            end
            r_head  <= r_head ^ w_resp_fire;
            r_count <= r_count + {1'b0, w_req_fire} - {1'b0, w_resp_fire};

            if (w_req_fire) begin
                r_recv_cnt <= c_rcnt_load;
            end else if (r_recv_cnt != '0) begin
                r_recv_cnt <= r_recv_cnt - 1'b1;
            end

            if (w_resp_fire) begin
                r_send_cnt <= c_scnt_load;
            end else if (r_send_cnt != '0) begin
                r_send_cnt <= r_send_cnt - 1'b1;
            end
        end
    end

    // Payload reads as zero while the FIFO is empty
    always_comb begin
        o_resp_op     = 1'b0;
        o_resp_opaque = '0;
        o_resp_addr   = '0;
        o_resp_data   = '0;
        if (r_count != 2'd0) begin
            o_resp_op     = r_fifo_op[r_head];
            o_resp_opaque = r_fifo_opaque[r_head];
            o_resp_addr   = r_fifo_addr[r_head];
            o_resp_data   = r_fifo_data[r_head];
        end
    end

endmodule
